// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush/stall handling and bubble/stall
// performance counters. Control fields are zeroed whenever the EX slot does
// not hold a real instruction; data fields are left alone on a flush because
// nothing downstream consumes them without a valid control word.
module id_ex_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  am_in,
  input  logic        rf_en_in,
  input  logic [3:0]  alu_op_in,
  input  logic        Load_in,
  input  logic        branch_link_in,
  input  logic        s_bit_in,
  input  logic        rw_in,
  input  logic        size_in,
  input  logic        datamem_en_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rn_val_in,
  input  logic [31:0] rm_val_in,
  input  logic [31:0] rd_val_in,
  input  logic [11:0] shift_op_in,
  input  logic [3:0]  rd_num_in,
  input  logic [3:0]  cond_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        clr_cnt,
  output logic [1:0]  am_ex,
  output logic        rf_en_ex,
  output logic [3:0]  alu_op_ex,
  output logic        Load_ex,
  output logic        branch_link_ex,
  output logic        s_bit_ex,
  output logic        rw_ex,
  output logic        size_ex,
  output logic        datamem_en_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] rn_val_ex,
  output logic [31:0] rm_val_ex,
  output logic [31:0] rd_val_ex,
  output logic [11:0] shift_op_ex,
  output logic [3:0]  rd_num_ex,
  output logic [3:0]  cond_ex,
  output logic        valid_ex,
  output logic [15:0] bubble_cnt,
  output logic [15:0] stall_cnt
);

  logic load;
  logic bubble_evt;
  logic stall_evt;

  // Mode decode: flush wins over stall, stall wins over load
  always_comb begin
    load       = !flush && !stall;
    bubble_evt = flush || (load && !valid_in);
    stall_evt  = stall && !flush;
  end

  // Control word and valid bit: cleared on flush or when loading a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex       <= 1'b0;
      am_ex          <= 2'd0;
      rf_en_ex       <= 1'b0;
      alu_op_ex      <= 4'd0;
      Load_ex        <= 1'b0;
      branch_link_ex <= 1'b0;
      s_bit_ex       <= 1'b0;
      rw_ex          <= 1'b0;
      size_ex        <= 1'b0;
      datamem_en_ex  <= 1'b0;
    end else if (flush || (load && !valid_in)) begin
      valid_ex       <= 1'b0;
      am_ex          <= 2'd0;
      rf_en_ex       <= 1'b0;
      alu_op_ex      <= 4'd0;
      Load_ex        <= 1'b0;
      branch_link_ex <= 1'b0;
      s_bit_ex       <= 1'b0;
      rw_ex          <= 1'b0;
      size_ex        <= 1'b0;
      datamem_en_ex  <= 1'b0;
    end else if (load) begin
      valid_ex       <= 1'b1;
      am_ex          <= am_in;
      rf_en_ex       <= rf_en_in;
      alu_op_ex      <= alu_op_in;
      Load_ex        <= Load_in;
      branch_link_ex <= branch_link_in;
      s_bit_ex       <= s_bit_in;
      rw_ex          <= rw_in;
      size_ex        <= size_in;
      datamem_en_ex  <= datamem_en_in;
    end
  end

  // Data fields: captured on every load, held on stall and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ex       <= 32'd0;
      rn_val_ex   <= 32'd0;
      rm_val_ex   <= 32'd0;
      rd_val_ex   <= 32'd0;
      shift_op_ex <= 12'd0;
      rd_num_ex   <= 4'd0;
      cond_ex     <= 4'd0;
    end else if (load) begin
      pc_ex       <= pc_in;
      rn_val_ex   <= rn_val_in;
      rm_val_ex   <= rm_val_in;
      rd_val_ex   <= rd_val_in;
      shift_op_ex <= shift_op_in;
      rd_num_ex   <= rd_num_in;
      cond_ex     <= cond_in;
    end
  end

  // Saturating perf counters; clear overrides any increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 16'd0;
      stall_cnt  <= 16'd0;
    end else if (clr_cnt) begin
      bubble_cnt <= 16'd0;
      stall_cnt  <= 16'd0;
    end else begin
      if (bubble_evt && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
      if (stall_evt && (stall_cnt != 16'hFFFF))   stall_cnt  <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs am_in 2, rf_en_in 1, alu_op_in 4, Load_in 1, branch_link_in 1, s_bit_in 1, rw_in 1, size_in 1, datamem_en_in 1: decode-stage control word after NOP-insertion mux.
REQ-004 SHALL have inputs pc_in 32, rn_val_in 32, rm_val_in 32, rd_val_in 32 (store data), shift_op_in 12, rd_num_in 4, cond_in 4: decode-stage operand/data fields.
REQ-005 SHALL have input valid_in, 1: decode slot holds a real instruction.
REQ-006 SHALL have inputs stall 1 (hold register), flush 1 (kill register contents), clr_cnt 1 (clear perf counters).
REQ-007 SHALL have outputs am_ex, rf_en_ex, alu_op_ex, Load_ex, branch_link_ex, s_bit_ex, rw_ex, size_ex, datamem_en_ex, same widths as REQ-003 inputs.
REQ-008 SHALL have outputs pc_ex, rn_val_ex, rm_val_ex, rd_val_ex, shift_op_ex, rd_num_ex, cond_ex, same widths as REQ-004 inputs.
REQ-009 SHALL have output valid_ex, 1: EX slot holds a real instruction.
REQ-010 SHALL have outputs bubble_cnt 16 and stall_cnt 16: saturating performance counters.

Function
REQ-011 SHALL operate in one of three modes per cycle, priority flush > stall > load.
REQ-012 Flush: SHALL set valid_ex=0 and all control outputs (REQ-007) to 0 on the next edge; data outputs (REQ-008) SHALL hold.
REQ-013 Stall (flush=0): SHALL hold every output, including valid_ex, unchanged.
REQ-014 Load (flush=0, stall=0): SHALL capture all REQ-003/REQ-004 inputs and valid_in; latency exactly one cycle.
REQ-015 Load with valid_in=0: SHALL force all control outputs to 0 regardless of control inputs; data fields captured normally.
REQ-016 Control outputs SHALL never be nonzero while valid_ex=0.
REQ-017 bubble_cnt SHALL increment by 1 on each edge where flush=1, or load occurs with valid_in=0.
REQ-018 stall_cnt SHALL increment by 1 on each edge where stall=1 and flush=0; stall and flush together counts as bubble only.
REQ-019 Both counters SHALL saturate at 0xFFFF (no wrap).
REQ-020 clr_cnt=1 SHALL set both counters to 0 on the next edge, overriding any increment that cycle; pipeline contents unaffected.
REQ-021 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) set every output, including counters and valid_ex, to 0.
REQ-023 Reset asserted mid-stall or mid-flush SHALL override; first edge after rst_n rises SHALL perform a normal mode decision per REQ-011.

Verification
REQ-024 Reset then load valid_in=1, alu_op_in=4'hA, rn_val_in=32'h1234_5678, rd_num_in=4'h3 -> next edge alu_op_ex=4'hA, rn_val_ex=32'h1234_5678, rd_num_ex=3, valid_ex=1, counters 0.
REQ-025 Loaded entry, stall=1 for 3 cycles while inputs change -> outputs unchanged for 3 cycles, stall_cnt=3, bubble_cnt=0.
REQ-026 Loaded entry with Load_ex=1, assert stall=1 and flush=1 together -> next edge valid_ex=0, Load_ex=0, rn_val_ex unchanged, bubble_cnt=1, stall_cnt=0.
REQ-027 Load with valid_in=0, rf_en_in=1, datamem_en_in=1 -> rf_en_ex=0, datamem_en_ex=0, valid_ex=0, bubble_cnt increments by 1.
REQ-028 Preload stall_cnt to 0xFFFE via 0xFFFE stall cycles, stall 3 more -> stall_cnt=0xFFFF held; then clr_cnt=1 with stall=1 -> stall_cnt=0.
REQ-029 Drop rst_n between clock edges during stall with valid_ex=1 -> all outputs 0 before next rising edge.
